// File: rtl/router_egress_arb_if.sv
// Egress link bundle: the per-port show-ahead FIFO read side plus the
// registered output flit channel with its val/rdy handshake.
//   req_mty  FIFO empty flags, bit i = port i
//   req_dat  FIFO head flits, port i at [i*PORT_WIDTH +: PORT_WIDTH]
//   req_rd   FIFO pop strobes (one-hot or zero)
//   out_val / out_dat / out_rdy  downstream flit channel
// master = arbiter side, slave = FIFO/downstream side.
interface router_egress_arb_if #(
    parameter int NUM_PORTS  = 5,
    parameter int PORT_WIDTH = 128
) ();
    logic [NUM_PORTS-1:0]            req_mty;
    logic [NUM_PORTS*PORT_WIDTH-1:0] req_dat;
    logic [NUM_PORTS-1:0]            req_rd;
    logic                            out_val;
    logic [PORT_WIDTH-1:0]           out_dat;
    logic                            out_rdy;

    modport master (
        input  req_mty, req_dat, out_rdy,
        output req_rd, out_val, out_dat
    );

    modport slave (
        output req_mty, req_dat, out_rdy,
        input  req_rd, out_val, out_dat
    );
endinterface

// File: rtl/router_egress_arb.sv
// Egress switch stage: round-robin arbitration over NUM_PORTS ingress
// FIFOs with wormhole locking (head..tail holds the grant), feeding one
// registered output slice.
//   clk, arst   clock, asynchronous active-low reset
//   link        router_egress_arb_if.master (FIFO read side + output flit)
//   grant_port  port holding the lock (meaningful while locked=1)
//   locked      a packet is in progress
//   err_proto   one-cycle pulse on a flit-type protocol error
//   pkt_cnt     packets fully forwarded, saturating
module router_egress_arb #(
    parameter int NUM_PORTS  = 5,
    parameter int PORT_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         arst,
    router_egress_arb_if.master          link,
    output logic [$clog2(NUM_PORTS)-1:0] grant_port,
    output logic                         locked,
    output logic                         err_proto,
    output logic [CNT_WIDTH-1:0]         pkt_cnt
);
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_HEAD   = 2'b01,
        FT_BODY   = 2'b10,
        FT_TAIL   = 2'b11
    } flit_t;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_port_q, grant_port_d;
    logic                   out_val_q, out_val_d;
    logic [PORT_WIDTH-1:0]  out_dat_q, out_dat_d;
    logic                   err_proto_q, err_proto_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] port_dat;
    logic [NUM_PORTS-1:0]  pop_vec;
    logic [GW-1:0]         sel, src;
    logic                  found, avail, load;
    logic [PORT_WIDTH-1:0] head_dat;
    flit_t                 ftype;
    logic [1:0]            cnt_inc;
    logic [CNT_WIDTH:0]    cnt_sum;
    int                    idx;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign port_dat[g] = link.req_dat[g*PORT_WIDTH +: PORT_WIDTH];
    end

    assign load = !out_val_q || link.out_rdy;

    // Round-robin pick: first non-empty port after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && !link.req_mty[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
    end

    // While locked only the owning port is considered.
    assign src      = (state_q == S_LOCKED) ? grant_port_q : sel;
    assign avail    = (state_q == S_LOCKED) ? !link.req_mty[grant_port_q] : found;
    assign head_dat = port_dat[src];
    assign ftype    = flit_t'(head_dat[PORT_WIDTH-1 -: 2]);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_port_d = grant_port_q;
        // Holds while stalled; drops once accepted unless refilled below.
        out_val_d    = out_val_q && !link.out_rdy;
        out_dat_d    = out_dat_q;
        err_proto_d  = 1'b0;
        cnt_inc      = 2'd0;
        pop_vec      = '0;

        if (load && avail) begin
            pop_vec[src] = 1'b1;
            if (state_q == S_IDLE) begin
                unique case (ftype)
                    FT_SINGLE: begin
                        out_val_d = 1'b1;
                        out_dat_d = head_dat;
                        rr_ptr_d  = sel;
                        cnt_inc   = 2'd1;
                    end
                    FT_HEAD: begin
                        out_val_d    = 1'b1;
                        out_dat_d    = head_dat;
                        grant_port_d = sel;
                        state_d      = S_LOCKED;
                    end
                    default: begin
                        // Orphan body/tail: discard so the port cannot wedge.
                        err_proto_d = 1'b1;
                        rr_ptr_d    = sel;
                    end
                endcase
            end else begin
                out_val_d = 1'b1;
                out_dat_d = head_dat;
                unique case (ftype)
                    FT_BODY: ;
                    FT_TAIL: begin
                        rr_ptr_d = grant_port_q;
                        cnt_inc  = 2'd1;
                        state_d  = S_IDLE;
                    end
                    FT_HEAD: begin
                        // Unterminated packet closed; new one opens on same port.
                        err_proto_d = 1'b1;
                        cnt_inc     = 2'd1;
                    end
                    default: begin
                        // Single inside a packet closes the open one and itself.
                        err_proto_d = 1'b1;
                        cnt_inc     = 2'd2;
                        rr_ptr_d    = grant_port_q;
                        state_d     = S_IDLE;
                    end
                endcase
            end
        end

        cnt_sum   = {1'b0, pkt_cnt_q} + (CNT_WIDTH+1)'(cnt_inc);
        pkt_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= GW'(NUM_PORTS-1);
            grant_port_q <= '0;
            out_val_q    <= 1'b0;
            out_dat_q    <= '0;
            err_proto_q  <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_port_q <= grant_port_d;
            out_val_q    <= out_val_d;
            out_dat_q    <= out_dat_d;
            err_proto_q  <= err_proto_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    // Pop strobes are combinational; gate with reset so no FIFO pops in reset.
    assign link.req_rd  = pop_vec & {NUM_PORTS{arst}};
    assign link.out_val = out_val_q;
    assign link.out_dat = out_dat_q;
    assign grant_port   = grant_port_q;
    assign locked       = (state_q == S_LOCKED);
    assign err_proto    = err_proto_q;
    assign pkt_cnt      = pkt_cnt_q;
endmodule

// File: tb/tb_router_egress_arb.sv
module tb_router_egress_arb;
    localparam int NP = 5;
    localparam int PW = 16;
    localparam int CW = 4;
    localparam logic [1:0] T_S = 2'b00, T_H = 2'b01, T_B = 2'b10, T_T = 2'b11;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic [2:0]    grant_port;
    logic          locked, err_proto;
    logic [CW-1:0] pkt_cnt;

    router_egress_arb_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW)) ifc ();

    router_egress_arb #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .arst(arst), .link(ifc.master),
        .grant_port(grant_port), .locked(locked),
        .err_proto(err_proto), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PW-1:0] dat; int cyc; } acc_t;

    logic [PW-1:0] fq [NP][$];
    acc_t          log_q [$];
    int            total = 0, bad = 0, cyc = 0;

    // Negedge snapshot of the cycle just finished.
    logic [NP-1:0] s_rd;
    logic          s_val, s_locked, s_err, s_acc;
    logic [PW-1:0] s_dat;
    logic [2:0]    s_grant;
    logic [CW-1:0] s_cnt;

    function automatic logic [PW-1:0] mk(input logic [1:0] t, input int p, input int s);
        return {t, 2'b00, 4'(p), 8'(s)};
    endfunction

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            ifc.req_mty[i]          = (fq[i].size() == 0);
            ifc.req_dat[i*PW +: PW] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    // One clock: sample at negedge, then apply FIFO pops / log accepted flit after the edge.
    task automatic step();
        @(negedge clk);
        s_rd = ifc.req_rd; s_val = ifc.out_val; s_dat = ifc.out_dat;
        s_locked = locked; s_grant = grant_port; s_err = err_proto; s_cnt = pkt_cnt;
        s_acc = ifc.out_val & ifc.out_rdy;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < NP; i++)
            if (s_rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        if (s_acc) log_q.push_back('{s_dat, cyc});
        refresh();
    endtask

    task automatic do_reset();
        arst = 1'b0;
        for (int i = 0; i < NP; i++) fq[i].delete();
        refresh();
        ifc.out_rdy = 1'b1;
        step(); step();
        log_q.delete();
        arst = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NP; i++) fq[i].push_back(mk(T_S, i, 0));
        ifc.out_rdy = 1'b1;
        refresh();
        step();
        total++; if (s_rd !== 5'b0) begin bad++; $display("FAIL rst_req_rd got=%b exp=00000", s_rd); end
        total++; if ({s_val, s_locked, s_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {s_val, s_locked, s_err}); end
        total++; if ({s_cnt, s_grant} !== 7'd0) begin bad++; $display("FAIL rst_cnt_grant got=%0h exp=0", {s_cnt, s_grant}); end
        arst = 1'b1;
        step();
        total++; if (s_rd !== 5'b00001) begin bad++; $display("FAIL first_grant got=%b exp=00001", s_rd); end
        step();
        total++; if (s_val !== 1'b1 || s_dat !== mk(T_S, 0, 0)) begin bad++; $display("FAIL first_flit got=%b/%h exp=1/%h", s_val, s_dat, mk(T_S, 0, 0)); end
        total++; if (s_rd !== 5'b00010) begin bad++; $display("FAIL second_grant got=%b exp=00010", s_rd); end
    endtask

    task automatic test_rr();
        do_reset();
        fq[0].push_back(mk(T_S, 0, 1));
        fq[2].push_back(mk(T_S, 2, 1));
        fq[4].push_back(mk(T_S, 4, 1));
        refresh();
        repeat (6) step();
        total++; if (log_q.size() !== 3) begin bad++; $display("FAIL rr_count got=%0d exp=3", log_q.size()); end
        if (log_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (log_q[k].dat !== mk(T_S, 2*k, 1)) begin bad++; $display("FAIL rr_order[%0d] got=%h exp=%h", k, log_q[k].dat, mk(T_S, 2*k, 1)); end
            end
            total++; if (log_q[2].cyc - log_q[0].cyc !== 2) begin bad++; $display("FAIL rr_b2b got=%0d exp=2", log_q[2].cyc - log_q[0].cyc); end
        end
        total++; if (s_cnt !== 4'd3) begin bad++; $display("FAIL rr_pkt_cnt got=%0d exp=3", s_cnt); end
    endtask

    task automatic test_wormhole();
        logic [PW-1:0] exp [5];
        int lk = 0;
        do_reset();
        exp = '{mk(T_H, 1, 0), mk(T_B, 1, 1), mk(T_B, 1, 2), mk(T_T, 1, 3), mk(T_S, 3, 0)};
        for (int k = 0; k < 4; k++) fq[1].push_back(exp[k]);
        fq[3].push_back(exp[4]);
        refresh();
        repeat (10) begin
            step();
            if (s_locked) begin
                lk++;
                total++; if (s_grant !== 3'd1) begin bad++; $display("FAIL wh_grant got=%0d exp=1", s_grant); end
            end
        end
        // Head pop enters LOCKED; the tail leaves it on the edge that pops it,
        // so a 4-flit packet is seen locked in 3 sampled cycles.
        total++; if (lk !== 3) begin bad++; $display("FAIL wh_locked_cycles got=%0d exp=3", lk); end
        total++; if (log_q.size() !== 5) begin bad++; $display("FAIL wh_count got=%0d exp=5", log_q.size()); end
        if (log_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (log_q[k].dat !== exp[k]) begin bad++; $display("FAIL wh_flit[%0d] got=%h exp=%h", k, log_q[k].dat, exp[k]); end
            end
            total++; if (log_q[4].cyc - log_q[0].cyc !== 4) begin bad++; $display("FAIL wh_b2b got=%0d exp=4", log_q[4].cyc - log_q[0].cyc); end
        end
        total++; if (s_cnt !== 4'd2) begin bad++; $display("FAIL wh_pkt_cnt got=%0d exp=2", s_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp [5];
        do_reset();
        exp = '{mk(T_H, 0, 0), mk(T_B, 0, 1), mk(T_B, 0, 2), mk(T_B, 0, 3), mk(T_T, 0, 4)};
        for (int k = 0; k < 5; k++) fq[0].push_back(exp[k]);
        refresh();
        step(); step();
        ifc.out_rdy = 1'b0;
        repeat (5) begin
            step();
            total++;
            if (s_rd !== 5'b0 || s_val !== 1'b1 || s_dat !== exp[1]) begin
                bad++; $display("FAIL bp_hold got=%b/%b/%h exp=00000/1/%h", s_rd, s_val, s_dat, exp[1]);
            end
        end
        ifc.out_rdy = 1'b1;
        repeat (8) step();
        total++; if (log_q.size() !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", log_q.size()); end
        if (log_q.size() == 5)
            for (int k = 0; k < 5; k++) begin
                total++;
                if (log_q[k].dat !== exp[k]) begin bad++; $display("FAIL bp_flit[%0d] got=%h exp=%h", k, log_q[k].dat, exp[k]); end
            end
    endtask

    task automatic test_drop();
        int errs = 0, vals = 0;
        do_reset();
        fq[2].push_back(mk(T_B, 2, 7));
        refresh();
        repeat (5) begin
            step();
            errs += int'(s_err);
            vals += int'(s_val);
        end
        total++; if (errs !== 1) begin bad++; $display("FAIL drop_err_pulses got=%0d exp=1", errs); end
        total++; if (vals !== 0) begin bad++; $display("FAIL drop_out_val got=%0d exp=0", vals); end
        total++; if (s_cnt !== 4'd0) begin bad++; $display("FAIL drop_pkt_cnt got=%0d exp=0", s_cnt); end
        total++; if (fq[2].size() !== 0) begin bad++; $display("FAIL drop_popped got=%0d exp=0", fq[2].size()); end
    endtask

    task automatic test_locked_err();
        int errs = 0;
        do_reset();
        fq[0].push_back(mk(T_H, 0, 0));
        fq[0].push_back(mk(T_S, 0, 1));
        refresh();
        repeat (5) begin
            step();
            errs += int'(s_err);
        end
        total++; if (errs !== 1) begin bad++; $display("FAIL lerr_pulses got=%0d exp=1", errs); end
        total++; if (log_q.size() !== 2) begin bad++; $display("FAIL lerr_count got=%0d exp=2", log_q.size()); end
        total++; if (s_cnt !== 4'd2) begin bad++; $display("FAIL lerr_pkt_cnt got=%0d exp=2", s_cnt); end
        total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL lerr_unlocked got=%b exp=0", s_locked); end
    endtask

    task automatic test_saturate_async();
        do_reset();
        for (int k = 0; k < 20; k++) fq[0].push_back(mk(T_S, 0, k));
        refresh();
        repeat (24) step();
        total++; if (log_q.size() !== 20) begin bad++; $display("FAIL sat_count got=%0d exp=20", log_q.size()); end
        total++; if (s_cnt !== 4'hF) begin bad++; $display("FAIL sat_pkt_cnt got=%0d exp=15", s_cnt); end
        fq[1].push_back(mk(T_H, 1, 0));
        fq[1].push_back(mk(T_B, 1, 1));
        refresh();
        step();
        ifc.out_rdy = 1'b0;
        step();
        total++; if ({s_locked, s_val} !== 2'b11) begin bad++; $display("FAIL async_pre got=%b exp=11", {s_locked, s_val}); end
        #2 arst = 1'b0;
        #1;
        total++; if ({locked, ifc.out_val} !== 2'b00) begin bad++; $display("FAIL async_rst got=%b exp=00", {locked, ifc.out_val}); end
        total++; if (ifc.req_rd !== 5'b0) begin bad++; $display("FAIL async_req_rd got=%b exp=00000", ifc.req_rd); end
    endtask

    initial begin
        ifc.out_rdy = 1'b1;
        refresh();
        test_reset();
        test_rr();
        test_wormhole();
        test_back_to_back();
        test_drop();
        test_locked_err();
        test_saturate_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
